// File: rtl/ram_copy_engine.sv
// Block-copy initiator for a single-clock RAM with 1-cycle registered read latency.
// Streams one word per cycle and picks the copy direction so overlapping moves keep the source intact.
module ram_copy_engine #(
    parameter int addr_size = 8,
    parameter int data_size = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [addr_size-1:0] src_addr,
    input  logic [addr_size-1:0] dst_addr,
    input  logic [addr_size:0]   len,
    output logic                 busy,
    output logic                 done,
    output logic                 ram_rd_en,
    output logic [addr_size-1:0] ram_rd_addr,
    input  logic [data_size-1:0] ram_rd_data,
    output logic                 ram_wr_en,
    output logic [addr_size-1:0] ram_wr_addr,
    output logic [data_size-1:0] ram_wr_data
);

    localparam int AW = addr_size;
    localparam int LW = addr_size + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state_r, state_s;
    logic [AW-1:0] rd_ptr_r, rd_ptr_s;
    logic [AW-1:0] wr_ptr_r, wr_ptr_s;
    logic [LW-1:0] rem_r, rem_s;
    logic          desc_r, desc_s;

    logic          busy_s, done_s, rd_en_s, wr_en_s;
    logic [AW-1:0] rd_addr_s, wr_addr_s;

    logic [LW-1:0] src_end_s;
    logic [AW-1:0] len_m1_s, rd_first_s, wr_first_s, start_step_s, step_s;
    logic          start_desc_s;

    // Decode the copy geometry from the live inputs; only used on the accepting edge.
    always_comb begin
        src_end_s    = {1'b0, src_addr} + len;
        start_desc_s = ({1'b0, dst_addr} > {1'b0, src_addr}) && ({1'b0, dst_addr} < src_end_s);
        len_m1_s     = len[AW-1:0] - {{(AW-1){1'b0}}, 1'b1};
        if (start_desc_s) begin
            rd_first_s   = src_addr + len_m1_s;
            wr_first_s   = dst_addr + len_m1_s;
            start_step_s = {AW{1'b1}};
        end else begin
            rd_first_s   = src_addr;
            wr_first_s   = dst_addr;
            start_step_s = {{(AW-1){1'b0}}, 1'b1};
        end
        if (desc_r) begin
            step_s = {AW{1'b1}};
        end else begin
            step_s = {{(AW-1){1'b0}}, 1'b1};
        end
    end

    // Next-state and next-output logic; writes trail reads by exactly one cycle.
    always_comb begin
        state_s   = state_r;
        rd_ptr_s  = rd_ptr_r;
        wr_ptr_s  = wr_ptr_r;
        rem_s     = rem_r;
        desc_s    = desc_r;
        rd_en_s   = 1'b0;
        rd_addr_s = {AW{1'b0}};
        wr_en_s   = ram_rd_en;
        wr_addr_s = {AW{1'b0}};

        if (ram_rd_en) begin
            wr_addr_s = wr_ptr_r;
            wr_ptr_s  = wr_ptr_r + step_s;
        end else begin
            wr_ptr_s  = wr_ptr_r;
        end

        case (state_r)
            IDLE: begin
                if (start) begin
                    desc_s   = start_desc_s;
                    wr_ptr_s = wr_first_s;
                    if (len != {LW{1'b0}}) begin
                        state_s   = STREAM;
                        rd_en_s   = 1'b1;
                        rd_addr_s = rd_first_s;
                        rd_ptr_s  = rd_first_s + start_step_s;
                        rem_s     = len - {{AW{1'b0}}, 1'b1};
                    end else begin
                        // Empty copy still takes the two-cycle handshake, but touches no RAM.
                        state_s = DRAIN;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            STREAM: begin
                if (rem_r != {LW{1'b0}}) begin
                    rd_en_s   = 1'b1;
                    rd_addr_s = rd_ptr_r;
                    rd_ptr_s  = rd_ptr_r + step_s;
                    rem_s     = rem_r - {{AW{1'b0}}, 1'b1};
                end else begin
                    state_s = DRAIN;
                end
            end
            DRAIN:   state_s = DONE;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase

        busy_s = (state_s == STREAM) || (state_s == DRAIN);
        done_s = (state_s == DONE);
    end

    // State, datapath and registered port outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            rd_ptr_r    <= {AW{1'b0}};
            wr_ptr_r    <= {AW{1'b0}};
            rem_r       <= {LW{1'b0}};
            desc_r      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ram_rd_en   <= 1'b0;
            ram_rd_addr <= {AW{1'b0}};
            ram_wr_en   <= 1'b0;
            ram_wr_addr <= {AW{1'b0}};
        end else begin
            state_r     <= state_s;
            rd_ptr_r    <= rd_ptr_s;
            wr_ptr_r    <= wr_ptr_s;
            rem_r       <= rem_s;
            desc_r      <= desc_s;
            busy        <= busy_s;
            done        <= done_s;
            ram_rd_en   <= rd_en_s;
            ram_rd_addr <= rd_addr_s;
            ram_wr_en   <= wr_en_s;
            ram_wr_addr <= wr_addr_s;
        end
    end

    assign ram_wr_data = ram_rd_data;

endmodule

// File: tb/tb_ram_copy_engine.sv
// Directed bench for ram_copy_engine: behavioural RAM with registered read, port logs,
// hand-computed expectations checked with immediate assertions.
module tb_ram_copy_engine;

    logic       clk, rst, start;
    logic [7:0] src_addr, dst_addr;
    logic [8:0] len;
    logic       busy, done, ram_rd_en, ram_wr_en;
    logic [7:0] ram_rd_addr, ram_rd_data, ram_wr_addr, ram_wr_data;

    logic       poke_en, log_clr;
    logic [7:0] poke_addr, poke_data;
    logic [7:0] mem [256];
    logic [7:0] rd_log [$];
    logic [7:0] wr_log [$];
    logic [7:0] exp4 [4];

    int vectors = 0;
    int miscompares = 0;
    int lat;

    ram_copy_engine #(.addr_size(8), .data_size(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .busy(busy), .done(done),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data)
    );

    always #5 clk = ~clk;

    // RAM model (read-before-write on the same edge) plus port activity logs.
    always @(posedge clk) begin
        if (poke_en) mem[poke_addr] <= poke_data;
        if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        if (log_clr) begin
            rd_log.delete();
            wr_log.delete();
        end else begin
            if (ram_rd_en) rd_log.push_back(ram_rd_addr);
            if (ram_wr_en) wr_log.push_back(ram_wr_addr);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        step();
        poke_en = 1'b0;
    endtask

    task automatic clear_logs();
        log_clr = 1'b1;
        step();
        log_clr = 1'b0;
    endtask

    // Drive a start pulse; returns positioned in cycle 1 with inputs scrambled.
    task automatic kick(input logic [7:0] s, input logic [7:0] d, input logic [8:0] n);
        start = 1'b1; src_addr = s; dst_addr = d; len = n;
        step();
        start = 1'b0; src_addr = 8'h99; dst_addr = 8'h77; len = 9'd3;
    endtask

    task automatic wait_done(input int lat0, input int expl, input string tag);
        lat = lat0;
        while (done !== 1'b1 && lat < 400) begin
            step();
            lat++;
        end
        chk(tag, 32'(lat), 32'(expl));
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; start = 1'b0;
        src_addr = 8'h00; dst_addr = 8'h00; len = 9'd0;
        poke_en = 1'b0; poke_addr = 8'h00; poke_data = 8'h00; log_clr = 1'b1;
        step(); step();
        chk("reset_busy",  32'(busy),      32'd0);
        chk("reset_done",  32'(done),      32'd0);
        chk("reset_rd_en", 32'(ram_rd_en), 32'd0);
        chk("reset_wr_en", 32'(ram_wr_en), 32'd0);
        rst = 1'b0;
        step();

        poke(8'h10, 8'hA1); poke(8'h11, 8'hB2); poke(8'h12, 8'hC3); poke(8'h13, 8'hD4);
        for (int i = 0; i < 8; i++) poke(8'h20 + 8'(i), 8'(i));
        poke(8'hFE, 8'h11); poke(8'hFF, 8'h22); poke(8'h00, 8'h33); poke(8'h01, 8'h44);
        poke(8'h70, 8'h5A);
        log_clr = 1'b0;

        // Reset mid-copy
        kick(8'h00, 8'h60, 9'd10);
        step();
        rst = 1'b1; log_clr = 1'b1;
        step();
        chk("midrst_busy",  32'(busy),      32'd0);
        chk("midrst_done",  32'(done),      32'd0);
        chk("midrst_rd_en", 32'(ram_rd_en), 32'd0);
        chk("midrst_wr_en", 32'(ram_wr_en), 32'd0);
        log_clr = 1'b0;
        step(); step();
        rst = 1'b0;
        repeat (5) step();
        chk("midrst_no_wr", 32'(wr_log.size()), 32'd0);
        chk("midrst_no_rd", 32'(rd_log.size()), 32'd0);
        chk("midrst_idle",  32'(busy),          32'd0);

        // Plain ascending copy
        clear_logs();
        kick(8'h10, 8'h40, 9'd4);
        chk("asc_c1_rd_en", 32'(ram_rd_en),   32'd1);
        chk("asc_c1_rd_a",  32'(ram_rd_addr), 32'h10);
        chk("asc_c1_wr_en", 32'(ram_wr_en),   32'd0);
        chk("asc_c1_busy",  32'(busy),        32'd1);
        wait_done(1, 6, "asc_latency");
        step();
        chk("asc_done_pulse", 32'(done), 32'd0);
        exp4 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        for (int i = 0; i < 4; i++) chk("asc_mem", 32'(mem[8'h40 + 8'(i)]), 32'(exp4[i]));

        // Overlapping move, descending
        clear_logs();
        kick(8'h20, 8'h22, 9'd6);
        chk("dsc_c1_rd_a", 32'(ram_rd_addr), 32'h25);
        step();
        chk("dsc_c2_rd_a",  32'(ram_rd_addr), 32'h24);
        chk("dsc_c2_wr_en", 32'(ram_wr_en),   32'd1);
        chk("dsc_c2_wr_a",  32'(ram_wr_addr), 32'h27);
        chk("dsc_c2_wr_d",  32'(ram_wr_data), 32'h05);
        wait_done(2, 8, "dsc_latency");
        for (int i = 0; i < 8; i++)
            chk("dsc_mem", 32'(mem[8'h20 + 8'(i)]), (i < 2) ? 32'(i) : 32'(i - 2));
        chk("dsc_last_rd", 32'(rd_log[5]), 32'h20);
        chk("dsc_last_wr", 32'(wr_log[5]), 32'h22);

        // Zero-length request
        clear_logs();
        kick(8'h30, 8'h31, 9'd0);
        chk("len0_c1_busy", 32'(busy), 32'd1);
        chk("len0_c1_done", 32'(done), 32'd0);
        step();
        chk("len0_c2_done", 32'(done), 32'd1);
        chk("len0_c2_busy", 32'(busy), 32'd0);
        step();
        chk("len0_c3_done", 32'(done), 32'd0);
        chk("len0_no_rd", 32'(rd_log.size()), 32'd0);
        chk("len0_no_wr", 32'(wr_log.size()), 32'd0);

        // Address wrap
        clear_logs();
        kick(8'hFE, 8'h80, 9'd4);
        wait_done(1, 6, "wrap_latency");
        exp4 = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        for (int i = 0; i < 4; i++) chk("wrap_rd_a", 32'(rd_log[i]), 32'(exp4[i]));
        for (int i = 0; i < 4; i++) chk("wrap_wr_a", 32'(wr_log[i]), 32'(8'h80 + 8'(i)));
        exp4 = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) chk("wrap_mem", 32'(mem[8'h80 + 8'(i)]), 32'(exp4[i]));

        // Starts while busy and during done are ignored
        clear_logs();
        kick(8'h10, 8'h50, 9'd3);
        start = 1'b1; src_addr = 8'h30; dst_addr = 8'h70; len = 9'd5;
        step();
        start = 1'b0;
        chk("ign_busy", 32'(busy), 32'd1);
        wait_done(2, 5, "ign_latency");
        start = 1'b1; src_addr = 8'h30; dst_addr = 8'h70; len = 9'd5;
        step();
        start = 1'b0;
        chk("ign_after_done_busy", 32'(busy), 32'd0);
        repeat (3) step();
        chk("ign_still_idle", 32'(busy), 32'd0);
        chk("ign_rd_count", 32'(rd_log.size()), 32'd3);
        chk("ign_wr_count", 32'(wr_log.size()), 32'd3);
        exp4 = '{8'hA1, 8'hB2, 8'hC3, 8'h00};
        for (int i = 0; i < 3; i++) chk("ign_mem", 32'(mem[8'h50 + 8'(i)]), 32'(exp4[i]));
        chk("ign_dst_untouched", 32'(mem[8'h70]), 32'h5A);

        // Whole-RAM copy onto itself
        clear_logs();
        kick(8'h00, 8'h00, 9'h100);
        wait_done(1, 258, "full_latency");
        chk("full_rd_count", 32'(rd_log.size()), 32'd256);
        chk("full_wr_count", 32'(wr_log.size()), 32'd256);
        chk("full_first_rd", 32'(rd_log[0]),     32'h00);
        chk("full_last_wr",  32'(wr_log[255]),   32'hFF);
        chk("full_mem_keep", 32'(mem[8'h10]),    32'hA1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
